// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency SRAM port between instruction fetch and data access.
// Round-robin on ties; each access is IDLE -> BUSY (WAIT_CYCLES) -> DONE (one-cycle ready).
module mem_port_arbiter #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        freeze,
    output logic        if_stall,
    output logic        sram_en,
    output logic        sram_we,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic {GNT_IF = 1'b0, GNT_MEM = 1'b1} gnt_t;

    state_t        state_q, state_d;
    gnt_t          grant_q, grant_d;
    gnt_t          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          we_q, we_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          sram_en_d, sram_we_d, if_ready_d, mem_ready_d;

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (if_req || mem_req) begin
                    // On a tie the requester not served last wins
                    grant_d = (mem_req && (!if_req || last_q == GNT_IF)) ? GNT_MEM : GNT_IF;
                    if (grant_d == GNT_MEM) begin
                        addr_d  = mem_addr;
                        wdata_d = mem_wdata;
                        we_d    = mem_we;
                    end else begin
                        addr_d  = if_addr;
                        we_d    = 1'b0;
                    end
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    if (!we_q) begin
                        rdata_d = sram_rdata;
                    end
                    last_d  = grant_q;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        sram_en_d   = (state_d == BUSY);
        sram_we_d   = (state_d == BUSY) && we_d;
        if_ready_d  = (state_d == DONE) && (grant_d == GNT_IF);
        mem_ready_d = (state_d == DONE) && (grant_d == GNT_MEM);
    end

    // State and output registers; reset aborts any access in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            grant_q   <= GNT_IF;
            last_q    <= GNT_IF;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            rdata_q   <= '0;
            sram_en   <= 1'b0;
            sram_we   <= 1'b0;
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            rdata_q   <= rdata_d;
            sram_en   <= sram_en_d;
            sram_we   <= sram_we_d;
            if_ready  <= if_ready_d;
            mem_ready <= mem_ready_d;
        end
    end

    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;
    assign if_rdata   = rdata_q;
    assign mem_rdata  = rdata_q;

    // Pipeline hold signals react in the same cycle as the request/ready
    assign freeze   = mem_req & ~mem_ready;
    assign if_stall = if_req & ~if_ready;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Single-port memory arbiter and access sequencer for the 5-stage pipeline (IF, ID, EXE, MEM, WB). It shares one synchronous SRAM port between instruction fetch (IF stage) and data load/store (MEM stage), inserting wait states for a fixed-latency memory. It returns per-requester ready pulses and a pipeline freeze signal. It sits between the IF/MEM stages and the unified memory.

## Interface
- WAIT_CYCLES, 2: SRAM access latency in cycles, legal range 1..255.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- if_req  in  1  fetch request; held until if_ready.
- if_addr  in  32  fetch address.
- if_rdata  out  32  fetched word; valid only while if_ready=1.
- if_ready  out  1  one-cycle completion pulse for fetch.
- mem_req  in  1  data request; held until mem_ready.
- mem_we  in  1  1 = store, 0 = load.
- mem_addr  in  32  data address.
- mem_wdata  in  32  store data.
- mem_rdata  out  32  load data; valid only while mem_ready=1.
- mem_ready  out  1  one-cycle completion pulse for data access.
- freeze  out  1  mem_req & ~mem_ready; freezes all pipeline registers.
- if_stall  out  1  if_req & ~if_ready; holds PC/IF register only.
- sram_en  out  1  SRAM access enable.
- sram_we  out  1  SRAM write enable.
- sram_addr  out  32  SRAM address.
- sram_wdata  out  32  SRAM write data.
- sram_rdata  in  32  SRAM read data; valid on the WAIT_CYCLES-th consecutive cycle of a held sram_en/sram_addr.

## Operation
- States: IDLE, BUSY, DONE. Registers: state, grant (IF/MEM), last_grant, cnt (8 bit), addr_q, wdata_q, we_q, rdata_q.
- IDLE:
  - If neither request is pending, stay in IDLE.
  - If exactly one request is pending, grant it.
  - If both are pending, grant the requester not equal to last_grant (round-robin).
  - On any grant: latch the address; latch wdata and we for MEM (we_q=0 for IF); cnt←0; move to BUSY.
- BUSY:
  - sram_en=1, sram_we=we_q, sram_addr=addr_q, sram_wdata=wdata_q.
  - cnt increments each cycle.
  - When cnt==WAIT_CYCLES-1:
    - For a read, rdata_q←sram_rdata.
    - For a write, rdata_q is unchanged.
    - last_grant←grant; move to DONE.
- DONE: assert the ready of the granted requester only, for one cycle; next state is IDLE unconditionally.
- if_rdata and mem_rdata are both driven from rdata_q.
- sram_en and sram_we are 0 outside BUSY. sram_addr and sram_wdata hold their latched values.
- Request inputs are sampled only in IDLE. A request dropped during BUSY does not abort the access; the ready pulse is still issued.
- Both requesters see the same ready timing. There is no bypass and no back-to-back issue without IDLE.
- Reset (rst=0, asynchronous):
  - state=IDLE, grant=IF, last_grant=IF, so the first tie goes to MEM.
  - cnt=0; addr_q, wdata_q, rdata_q = 0; we_q=0.
  - Outputs: sram_en=0, sram_we=0, both readies 0.
  - freeze and if_stall follow their combinational equations.
- Reset mid-BUSY aborts the access immediately. No ready is issued. After release, a held request restarts from IDLE.

## Timing
- Request first seen in IDLE at cycle t:
  - BUSY during cycles t+1 .. t+WAIT_CYCLES.
  - ready during cycle t+WAIT_CYCLES+1.
- Access period is WAIT_CYCLES+2 cycles (4 at default).
- Ready, rdata and SRAM controls are registered (from state/registers). freeze and if_stall are combinational from inputs and ready.
- With both requests held continuously, grants alternate MEM, IF, MEM, … Each requester is served at most 2·(WAIT_CYCLES+2) cycles after the other completes, so there is no starvation.

## Test plan
- Single fetch, WAIT_CYCLES=2:
  - Stimulus: if_req=1 at cycle 0, if_addr=0x40, SRAM returns 0xDEADBEEF.
  - Required: sram_en=1 and sram_addr=0x40 in cycles 1–2; if_ready=1 with if_rdata=0xDEADBEEF in cycle 3; mem_ready stays 0.
- Tie after reset:
  - Stimulus: if_req and mem_req both asserted at cycle 0 and held until their ready.
  - Required: mem_ready in cycle 3, if_ready in cycle 7.
- Round-robin:
  - Stimulus: both requests held high for 16 cycles.
  - Required: ready pulses MEM@3, IF@7, MEM@11, IF@15.
- Store:
  - Stimulus: mem_we=1, mem_addr=0x100, mem_wdata=0x12345678.
  - Required: sram_we=1 with those address/data in cycles 1–2; mem_ready in cycle 3; rdata_q keeps its prior load value.
- Reset mid-access:
  - Stimulus: rst driven low during cycle 2 of a fetch.
  - Required: sram_en=0 immediately and no if_ready. After release with if_req held, a new access completes 3 cycles after the first IDLE cycle.
- Freeze and stall:
  - Stimulus: mem_req held from cycle 0.
  - Required: freeze=1 in cycles 0–2 and 0 in cycle 3. With if_req also held, if_stall=1 until its own ready.
